// File: rtl/multiplicador_pkg.sv
// Shared definitions for the multiplicador recomposer: state encoding,
// default operand width and the bit-counter width derived from it.
package multiplicador_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W     = (WIDTH_DEF > 1) ? $clog2(WIDTH_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUMA = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/multiplicador.sv
// multiplicador: rebuilds the dividend A = Q*B + R by shift-and-add, one
// partial product per clock, behind a start/done handshake with a busy flag.
// Optional feature: define MULTIPLICADOR_CHECK_EN to add the registered err
// output, which flags a remainder/divisor pair a divider could not produce
// (B = 0 or R >= B).
module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] A,
  output logic               busy,
  output logic               done
`ifdef MULTIPLICADOR_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     qReg;
  logic [WIDTH-1:0]     bReg;
  logic [WIDTH-1:0]     rReg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  // Zero-extended operands so every add happens at the full result width;
  // the maximum result is 2^(2W) - 2^W, so no carry-out is ever needed.
  logic [2*WIDTH-1:0]   bExt;
  logic [2*WIDTH-1:0]   rExt;
  assign bExt = {{WIDTH{1'b0}}, bReg};
  assign rExt = {{WIDTH{1'b0}}, rReg};

  // Control FSM and datapath: a start is accepted in IDLE or FIN, MUL adds
  // one shifted partial product per cycle, SUMA folds in R and loads A.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      qReg  <= '0;
      bReg  <= '0;
      rReg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      A     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MULTIPLICADOR_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            qReg  <= Q;
            bReg  <= B;
            rReg  <= R;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (qReg[cnt]) begin
            acc <= acc + (bExt << cnt);
          end
          if (cnt == CNT_LAST) begin
            state <= SUMA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SUMA: begin
          acc   <= acc + rExt;
          A     <= acc + rExt;
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef MULTIPLICADOR_CHECK_EN
          err   <= (bReg == '0) || (rReg >= bReg);
`endif
          state <= FIN;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
